formula_loader: RTL

FORMULA_LOADER -- requirements
Module: formula_loader

---
 rtl/formula_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/formula_loader.sv
// Formula loader: assembles a streamed CNF formula into a fixed-size frame and
// runs the downstream solver kernel until it reports a verdict.
package common;
   localparam int MAX_CLAUSES = 10;
   localparam int MAX_LITS    = 5;

   typedef struct packed {
      logic [2:0] id;
      logic       pol;
   } lit;

   typedef struct packed {
      lit [MAX_LITS-1:0] lits;
      logic [2:0]        len;
   } clause;

   typedef struct packed {
      clause [MAX_CLAUSES-1:0] clauses;
      logic [3:0]              count;
   } formula;

   localparam lit zero_lit = '0;
endpackage

// state | meaning
// IDLE  | waiting for load_start; last formula stays on out_formula
// LOAD  | accepting literals into out_formula
// RUN   | formula complete, find asserted until kernel_ended
// ERR   | malformed stream seen; waits for load_start
module formula_loader #(
   parameter int MAX_CLAUSES = common::MAX_CLAUSES,
   parameter int MAX_LITS    = common::MAX_LITS
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load_start,
   input  logic           lit_valid,
   output logic           lit_ready,
   input  common::lit     lit_in,
   input  logic           lit_eoc,
   input  logic           lit_eof,
   input  logic           kernel_ended,
   input  logic           kernel_sat,
   input  logic           kernel_unsat,
   output common::formula out_formula,
   output logic           find,
   output logic           busy,
   output logic           done,
   output logic           result_sat,
   output logic           result_unsat,
   output logic           load_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

   state_t     state;
   logic [3:0] clause_idx;
   logic [2:0] lit_idx;
   logic       xfer;
   logic       bad_lit;

   assign xfer    = lit_valid && lit_ready;
   assign bad_lit = (lit_in.id == 3'b000) ||
                    (lit_idx == 3'(MAX_LITS)) ||
                    (clause_idx == 4'(MAX_CLAUSES));

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         out_formula  <= '0;
         clause_idx   <= '0;
         lit_idx      <= '0;
         lit_ready    <= 1'b0;
         find         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_sat   <= 1'b0;
         result_unsat <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (load_start) begin
                  state        <= LOAD;
                  out_formula  <= '0;
                  clause_idx   <= '0;
                  lit_idx      <= '0;
                  load_err     <= 1'b0;
                  result_sat   <= 1'b0;
                  result_unsat <= 1'b0;
                  lit_ready    <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (bad_lit) begin
                     // offending literal is dropped; frame keeps what was loaded so far
                     state     <= ERR;
                     load_err  <= 1'b1;
                     lit_ready <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     out_formula.clauses[clause_idx].lits[lit_idx] <= lit_in;
                     if (lit_eoc || lit_eof) begin
                        out_formula.clauses[clause_idx].len <= lit_idx + 3'd1;
                        clause_idx <= clause_idx + 4'd1;
                        lit_idx    <= '0;
                     end else begin
                        lit_idx <= lit_idx + 3'd1;
                     end
                     if (lit_eof) begin
                        out_formula.count <= clause_idx + 4'd1;
                        state     <= RUN;
                        lit_ready <= 1'b0;
                        find      <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (kernel_ended) begin
                  state        <= IDLE;
                  result_sat   <= kernel_sat;
                  result_unsat <= kernel_unsat;
                  done         <= 1'b1;
                  find         <= 1'b0;
                  busy         <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
